// File: rtl/pe_lanes_if.sv
// pe_lanes_if: datapath bundle between the activation buffer side (master)
// and the multi-lane PE (slave).
//
// Handshake: there is no backpressure. A beat is transferred on every rising
// clock edge where in_valid=1 and head=0 while the PE accumulates. head=1 is
// a header beat carrying the dot-product length in x_in[COUNT_W-1:0]. It is
// accepted in any state and takes priority over in_valid. Results in pe_out
// are valid while done_flag=1.
interface pe_lanes_if #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 16,
  parameter int COUNT_W = 10
);
  logic                      head;
  logic [DATA_W-1:0]         x_in;
  logic                      in_valid;
  logic [LANES*DATA_W-1:0]   w;
  logic [LANES*DATA_W-1:0]   b;
  logic [LANES*DATA_W-1:0]   pe_out;
  logic                      done_flag;
  logic                      busy;
  logic [1:0]                fsm_state;

  modport master (
    output head, x_in, in_valid, w, b,
    input  pe_out, done_flag, busy, fsm_state
  );

  modport slave (
    input  head, x_in, in_valid, w, b,
    output pe_out, done_flag, busy, fsm_state
  );
endinterface

// File: rtl/pe_lanes.sv
// pe_lanes: LANES parallel fixed-point neurons sharing one broadcast activation
// stream. A header loads the length N. N valid beats accumulate w_i*x per lane.
// FINISH then adds the bias, rescales with a floor shift and saturates into
// pe_out.
// Optional feature macro: PE_RELU_EN clamps negative results to zero before
// saturation.
module pe_lanes #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int COUNT_W = 10
) (
  input logic        clock,
  input logic        reset,
  pe_lanes_if.slave  bus
);
  localparam int ACC_W = 2*DATA_W + COUNT_W;
  localparam int SUM_W = ACC_W + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [1:0]                state;
  logic [COUNT_W-1:0]        n_len;
  logic [COUNT_W-1:0]        cnt;
  logic [COUNT_W-1:0]        cnt_next;
  logic signed [ACC_W-1:0]   acc      [LANES];
  logic signed [ACC_W-1:0]   acc_sum  [LANES];
  logic signed [2*DATA_W-1:0] prod    [LANES];
  logic signed [SUM_W-1:0]   bias_sh  [LANES];
  logic signed [SUM_W-1:0]   total    [LANES];
  logic signed [SUM_W-1:0]   scaled   [LANES];
  logic [DATA_W-1:0]         res      [LANES];
  logic [LANES*DATA_W-1:0]   pe_out_q;

  // Per-lane MAC update and the FINISH-stage bias / rescale / saturate path.
  always_comb begin
    cnt_next = cnt + 1'b1;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = $signed({{DATA_W{bus.w[i*DATA_W+DATA_W-1]}}, bus.w[i*DATA_W +: DATA_W]})
              * $signed({{DATA_W{bus.x_in[DATA_W-1]}}, bus.x_in});
      acc_sum[i] = acc[i] + $signed({{COUNT_W{prod[i][2*DATA_W-1]}}, prod[i]});
      bias_sh[i] = $signed({{(SUM_W-DATA_W){bus.b[i*DATA_W+DATA_W-1]}},
                            bus.b[i*DATA_W +: DATA_W]}) <<< FRAC_W;
      total[i]   = $signed({acc[i][ACC_W-1], acc[i]}) + bias_sh[i];
      // Arithmetic shift gives floor rounding of the rescaled value.
      scaled[i]  = total[i] >>> FRAC_W;
`ifdef PE_RELU_EN
      if (scaled[i][SUM_W-1]) scaled[i] = '0;
`else
`endif
      if (scaled[i] > SAT_MAX)      res[i] = SAT_MAX[DATA_W-1:0];
      else if (scaled[i] < SAT_MIN) res[i] = SAT_MIN[DATA_W-1:0];
      else                          res[i] = scaled[i][DATA_W-1:0];
    end
  end

  // Control FSM, accumulators and the result register. A header always
  // restarts, discarding any partial sum. pe_out only moves on FINISH->DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      n_len    <= '0;
      cnt      <= '0;
      pe_out_q <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (bus.head) begin
      n_len <= bus.x_in[COUNT_W-1:0];
      cnt   <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
      state <= (bus.x_in[COUNT_W-1:0] != '0) ? ACCUM : FINISH;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            for (int i = 0; i < LANES; i++) acc[i] <= acc_sum[i];
            cnt <= cnt_next;
            if (cnt_next == n_len) state <= FINISH;
          end
        end
        FINISH: begin
          for (int i = 0; i < LANES; i++) pe_out_q[i*DATA_W +: DATA_W] <= res[i];
          state <= DONE;
        end
        default: state <= state;
      endcase
    end
  end

  assign bus.pe_out    = pe_out_q;
  assign bus.done_flag = (state == DONE);
  assign bus.busy      = (state == ACCUM) || (state == FINISH);
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_pe_lanes.sv
// tb_pe_lanes: directed vectors with hand-computed expected results for
// pe_lanes (LANES=4, DATA_W=16, FRAC_W=8, COUNT_W=10). Honours PE_RELU_EN.
module tb_pe_lanes;
  localparam int LANES   = 4;
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int COUNT_W = 10;

  logic clock = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic [DATA_W-1:0] exp_q[$];

  pe_lanes_if #(.LANES(LANES), .DATA_W(DATA_W), .COUNT_W(COUNT_W)) bus ();

  pe_lanes #(
    .LANES(LANES), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .COUNT_W(COUNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Single checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic header(input int n);
    bus.head = 1'b1;
    bus.x_in = DATA_W'(n);
    tick();
    bus.head = 1'b0;
  endtask

  task automatic beats(input logic [DATA_W-1:0] x, input int count);
    for (int k = 0; k < count; k++) begin
      bus.in_valid = 1'b1;
      bus.x_in     = x;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard
  task automatic expect4(input logic [DATA_W-1:0] l0, input logic [DATA_W-1:0] l1,
                         input logic [DATA_W-1:0] l2, input logic [DATA_W-1:0] l3);
    exp_q.push_back(l0);
    exp_q.push_back(l1);
    exp_q.push_back(l2);
    exp_q.push_back(l3);
  endtask

  task automatic check_outputs(input string tag);
    logic [DATA_W-1:0] e;
    for (int i = 0; i < LANES; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
      check($sformatf("%s lane%0d", tag, i), 32'(bus.pe_out[i*DATA_W +: DATA_W]), 32'(e));
    end
  endtask

  // Call right after the last accepted beat (or an N=0 header): the PE is in
  // FINISH, results land on the next edge.
  task automatic finish_checks(input string tag);
    check({tag, " finish done"}, 32'(bus.done_flag), 32'd0);
    check({tag, " finish busy"}, 32'(bus.busy), 32'd1);
    tick();
    check({tag, " done"}, 32'(bus.done_flag), 32'd1);
    check({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    check_outputs(tag);
  endtask

  logic [DATA_W-1:0] neg_lane_exp;
  logic [DATA_W-1:0] sat_neg_exp;
  logic [DATA_W-1:0] zero_l1_exp;
  logic [DATA_W-1:0] zero_l3_exp;

  initial begin
`ifdef PE_RELU_EN
    neg_lane_exp = 16'h0000;
    sat_neg_exp  = 16'h0000;
    zero_l1_exp  = 16'h0000;
    zero_l3_exp  = 16'h0000;
`else
    neg_lane_exp = 16'hFEE0;
    sat_neg_exp  = 16'h8000;
    zero_l1_exp  = 16'hFF00;
    zero_l3_exp  = 16'h8000;
`endif
    reset        = 1'b1;
    bus.head     = 1'b0;
    bus.x_in     = '0;
    bus.in_valid = 1'b0;
    bus.w        = '0;
    bus.b        = '0;
    tick();
    tick();
    check("reset pe_out lo", bus.pe_out[31:0], 32'd0);
    check("reset pe_out hi", bus.pe_out[63:32], 32'd0);
    check("reset done", 32'(bus.done_flag), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset state", 32'(bus.fsm_state), 32'd0);
    reset = 1'b0;
    tick();

    // Basic: 9 * 0.25 * 0.5 + 1.0 = 2.125
    bus.w = {4{16'h0080}};
    bus.b = {4{16'h0100}};
    header(9);
    check("basic accum busy", 32'(bus.busy), 32'd1);
    beats(16'h0040, 9);
    expect4(16'h0220, 16'h0220, 16'h0220, 16'h0220);
    finish_checks("basic");

    // in_valid in DONE is ignored, results held
    bus.in_valid = 1'b1;
    bus.x_in     = 16'h7FFF;
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("hold done", 32'(bus.done_flag), 32'd1);
    expect4(16'h0220, 16'h0220, 16'h0220, 16'h0220);
    check_outputs("hold");

    // Negative lane 2
    bus.w = {16'h0080, 16'hFF80, 16'h0080, 16'h0080};
    bus.b = '0;
    header(9);
    check("neg done dropped", 32'(bus.done_flag), 32'd0);
    beats(16'h0040, 9);
    expect4(16'h0120, 16'h0120, neg_lane_exp, 16'h0120);
    finish_checks("neg");

    // Positive saturation
    bus.w = {4{16'h7FFF}};
    bus.b = {4{16'h7FFF}};
    header(4);
    beats(16'h7FFF, 4);
    expect4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    finish_checks("sat_pos");

    // Negative saturation
    bus.w = {4{16'h8000}};
    header(4);
    beats(16'h7FFF, 4);
    expect4(sat_neg_exp, sat_neg_exp, sat_neg_exp, sat_neg_exp);
    finish_checks("sat_neg");

    // Gaps: valid pattern 1,0,1,0,1 with N=3
    bus.w = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    bus.b = '0;
    header(3);
    beats(16'h0100, 1);
    tick();
    beats(16'h0100, 1);
    tick();
    check("gaps early done", 32'(bus.done_flag), 32'd0);
    check("gaps early busy", 32'(bus.busy), 32'd1);
    check("gaps early state", 32'(bus.fsm_state), 32'd1);
    beats(16'h0100, 1);
    expect4(16'h0300, 16'h0600, 16'h0900, 16'h0C00);
    finish_checks("gaps");

    // Zero length: result is sat(b) one edge after the header
    bus.b = {16'h8000, 16'h7FFF, 16'hFF00, 16'h0100};
    header(0);
    expect4(16'h0100, zero_l1_exp, 16'h7FFF, zero_l3_exp);
    finish_checks("zero");

    // Abort: new header with simultaneous in_valid mid-ACCUM
    bus.w = {4{16'h0100}};
    bus.b = '0;
    header(3);
    beats(16'h0100, 2);
    check("abort pe_out held", 32'(bus.pe_out[15:0]), 32'h0100);
    bus.head     = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_in     = 16'd2;
    tick();
    bus.head     = 1'b0;
    bus.in_valid = 1'b0;
    check("abort restart busy", 32'(bus.busy), 32'd1);
    check("abort restart done", 32'(bus.done_flag), 32'd0);
    beats(16'h0200, 2);
    expect4(16'h0400, 16'h0400, 16'h0400, 16'h0400);
    finish_checks("abort");

    // Asynchronous reset mid-ACCUM
    header(5);
    beats(16'h0100, 2);
    reset = 1'b1;
    #1;
    check("areset pe_out lo", bus.pe_out[31:0], 32'd0);
    check("areset pe_out hi", bus.pe_out[63:32], 32'd0);
    check("areset done", 32'(bus.done_flag), 32'd0);
    check("areset busy", 32'(bus.busy), 32'd0);
    #2;
    reset = 1'b0;
    tick();

    // Recovery after reset: N=1, 1.0*1.0
    header(1);
    beats(16'h0100, 1);
    expect4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    finish_checks("recover");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
